// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//
// Sequences a single CPU load/store into a strobe-driven memory.
// Each access walks IDLE -> SETUP -> STROBE -> RELEASE -> DONE -> IDLE.
// Address and store data are set up one cycle before the strobe. They stay
// stable until the access completes.
//
// Parameter
//   STROBE_CYCLES  width of each trigRead/trigWrite pulse in clk cycles (1..15)
//
// Ports
//   clk           in   1   system clock, rising edge
//   reset         in   1   asynchronous, active-high reset
//   reqValid      in   1   CPU access request, sampled only while idle
//   memRead       in   1   request is a load
//   memWrite      in   1   request is a store
//   reqAddress    in   7   word address of the request
//   reqWriteData  in  32   store data
//   reqReady      out  1   controller idle and able to accept a request
//   done          out  1   one-cycle completion pulse
//   err           out  1   one-cycle pulse with done when load and store are both requested
//   loadData      out 32   most recent load result
//   address       out  7   word address presented to memory
//   writeData     out 32   store data presented to memory
//   trigWrite     out  1   memory write strobe (memory writes on its rising edge)
//   trigRead      out  1   memory read strobe (memory updates readData on its rising edge)
//   readData      in  32   data returned by memory
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int unsigned STROBE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reqValid,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [6:0]  reqAddress,
  input  logic [31:0] reqWriteData,
  output logic        reqReady,
  output logic        done,
  output logic        err,
  output logic [31:0] loadData,
  output logic [6:0]  address,
  output logic [31:0] writeData,
  output logic        trigWrite,
  output logic        trigRead,
  input  logic [31:0] readData
);

  // The counter is loaded with STROBE_CYCLES-1.
  // STROBE is left on the cycle where the counter reads zero.
  localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_RELEASE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        op_rd_q, op_rd_d;
  logic        op_wr_q, op_wr_d;
  logic [6:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] ldata_q, ldata_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        trig_rd_q, trig_rd_d;
  logic        trig_wr_q, trig_wr_d;

  // Next-state, request capture, strobe counter and load capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_rd_d = op_rd_q;
    op_wr_d = op_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ldata_d = ldata_q;

    case (state_q)
      ST_IDLE: begin
        if (reqValid) begin
          state_d = ST_SETUP;
          op_rd_d = memRead;
          op_wr_d = memWrite;
          addr_d  = reqAddress;
          wdata_d = reqWriteData;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_d = ST_STROBE;
        cnt_d   = STROBE_LOAD;
      end
      ST_STROBE: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RELEASE;
          // Memory has updated readData by now, because it reacts to the
          // rising edge of trigRead. Only a true load takes the result.
          if (op_rd_q && !op_wr_q) begin
            ldata_d = readData;
          end else begin
            ldata_d = ldata_q;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RELEASE: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output next values are decoded from the next state.
  // Every output is then a plain flop with no decode glitches at the pins.
  always_comb begin
    ready_d   = (state_d == ST_IDLE);
    done_d    = (state_d == ST_DONE);
    err_d     = (state_d == ST_DONE) && op_rd_d && op_wr_d;
    trig_rd_d = (state_d == ST_STROBE) && op_rd_d && !op_wr_d;
    trig_wr_d = (state_d == ST_STROBE) && op_wr_d && !op_rd_d;
  end

  // State, datapath and output registers.
  // Reset clears them immediately, which also drops any active strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      op_rd_q   <= 1'b0;
      op_wr_q   <= 1'b0;
      addr_q    <= 7'd0;
      wdata_q   <= 32'd0;
      ldata_q   <= 32'd0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      trig_rd_q <= 1'b0;
      trig_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_rd_q   <= op_rd_d;
      op_wr_q   <= op_wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      ldata_q   <= ldata_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      err_q     <= err_d;
      trig_rd_q <= trig_rd_d;
      trig_wr_q <= trig_wr_d;
    end
  end

  assign reqReady  = ready_q;
  assign done      = done_q;
  assign err       = err_q;
  assign loadData  = ldata_q;
  assign address   = addr_q;
  assign writeData = wdata_q;
  assign trigRead  = trig_rd_q;
  assign trigWrite = trig_wr_q;

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL have parameter STROBE_CYCLES, default 1, meaning the width in clk cycles of each trigRead/trigWrite pulse (legal range 1..15).
REQ-002 The block SHALL have port clk  input  1  single system clock, all state updates on rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port reqValid  input  1  CPU access request.
REQ-005 The block SHALL have port memRead  input  1  request is a load.
REQ-006 The block SHALL have port memWrite  input  1  request is a store.
REQ-007 The block SHALL have port reqAddress  input  7  word address of request.
REQ-008 The block SHALL have port reqWriteData  input  32  store data.
REQ-009 The block SHALL have port reqReady  output  1  block idle, can accept request.
REQ-010 The block SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 The block SHALL have port err  output  1  one-cycle pulse coincident with done for illegal request.
REQ-012 The block SHALL have port loadData  output  32  last captured load result.
REQ-013 The block SHALL have port address  output  7  word address to memory.
REQ-014 The block SHALL have port writeData  output  32  store data to memory.
REQ-015 The block SHALL have port trigWrite  output  1  memory write strobe; memory writes on its rising edge.
REQ-016 The block SHALL have port trigRead  output  1  memory read strobe; memory updates readData on its rising edge.
REQ-017 The block SHALL have port readData  input  32  data returned by memory.

Function
REQ-018 The FSM SHALL have states IDLE, SETUP, STROBE, RELEASE, DONE; reqReady SHALL be 1 only in IDLE.
REQ-019 A request SHALL be accepted at a rising clk edge where state=IDLE and reqValid=1; accept moves IDLE->SETUP and latches reqAddress into address, reqWriteData into writeData, and the op type.
REQ-020 address and writeData SHALL remain constant from SETUP through DONE and hold their last value in IDLE.
REQ-021 SETUP SHALL last exactly one cycle with both strobes 0, then go to STROBE.
REQ-022 STROBE SHALL last exactly STROBE_CYCLES cycles, tracked by a 4-bit down-counter, then go to RELEASE.
REQ-023 During STROBE: load -> trigRead=1, trigWrite=0; store -> trigWrite=1, trigRead=0.
REQ-024 trigRead and trigWrite SHALL be driven directly from flip-flops (glitch-free), SHALL never be 1 simultaneously, and SHALL be 0 outside STROBE.
REQ-025 For a load, loadData SHALL capture readData at the edge leaving STROBE; loadData SHALL be unchanged by stores, no-ops and errors.
REQ-026 RELEASE SHALL last one cycle with strobes 0, then go to DONE.
REQ-027 DONE SHALL last one cycle with done=1, then return to IDLE; done SHALL be 0 in all other states.
REQ-028 Latency: with acceptance at edge k, done SHALL be high in the cycle after edge k+2+STROBE_CYCLES; reqReady SHALL return to 1 after edge k+3+STROBE_CYCLES.
REQ-029 reqValid with memRead=1 and memWrite=1 SHALL be accepted, SHALL generate no strobe in STROBE, and SHALL assert err=1 together with done.
REQ-030 reqValid with memRead=0 and memWrite=0 SHALL run the full sequence as a no-op: no strobe, done=1, err=0.
REQ-031 reqValid and request inputs outside IDLE SHALL be ignored; no queueing.
REQ-032 A request presented in the IDLE cycle immediately after DONE SHALL be accepted with no extra bubble.

Reset
REQ-033 While reset=1, regardless of clk: state=IDLE, reqReady=1, done=0, err=0, trigRead=0, trigWrite=0, address=0, writeData=0, loadData=0, counter=0.
REQ-034 Reset asserted mid-operation SHALL drop any active strobe to 0 immediately and abandon the access with no done pulse; after deassertion the first clk edge may accept a request.

Verification
REQ-035 Store then load, STROBE_CYCLES=1: store addr 7'h05 data 32'hDEADBEEF, then load addr 7'h05 -> exactly one trigWrite pulse of 1 cycle, then one trigRead pulse, loadData=32'hDEADBEEF, done 3 cycles after each acceptance edge.
REQ-036 STROBE_CYCLES=4: load addr 7'h7F -> trigRead high exactly 4 cycles, done 6 cycles after acceptance, address stable 7'h7F throughout.
REQ-037 Illegal request memRead=memWrite=1 at addr 7'h10 -> no strobe edge, done=1 and err=1 in same cycle, loadData unchanged, memory word 7'h10 unchanged.
REQ-038 reqValid held high continuously with changing reqAddress -> only IDLE-cycle values accepted, back-to-back accesses with no bubble after DONE.
REQ-039 Reset asserted during STROBE of a store -> trigWrite falls asynchronously, all outputs at reset values, no done pulse, next request completes normally.
